// File: rtl/timer_pkg.sv
// Shared types for the timer bank: per-channel state encoding and mode constants.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chan_state_e;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: counts shared ticks up to its load value and raises a sticky
// pending flag on expiry; one-shot channels park in DONE until re-enabled.
module timer_channel
  import timer_pkg::*;
#(
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick_i,
  input  logic                     enable_i,
  input  logic                     oneshot_i,
  input  logic                     clear_i,
  input  logic [COUNTER_WIDTH-1:0] load_i,
  output logic [COUNTER_WIDTH-1:0] count_o,
  output logic                     pending_o
);

  chan_state_e              state_q, state_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic                     pend_q, pend_d;
  logic                     expire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    expire  = 1'b0;
    if (!enable_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = RUN;
          cnt_d   = '0;
        end
        RUN: begin
          // >= compare so a load lowered below the count expires on the next tick
          if (tick_i) begin
            if (cnt_q >= load_i) begin
              expire = 1'b1;
              cnt_d  = '0;
              if (oneshot_i == MODE_ONESHOT) state_d = DONE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        DONE: cnt_d = '0;
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    // expiry wins over a same-cycle clear
    pend_d = (pend_q & ~clear_i) | expire;
  end

  assign count_o   = cnt_q;
  assign pending_o = pend_q;

endmodule

// File: rtl/timer_bank_irq.sv
// Bank of NUM_CH timers sharing one prescaler tick, with a registered masked
// interrupt reduction over the per-channel pending flags.
module timer_bank_irq
  import timer_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int COUNTER_WIDTH   = 32,
  parameter int PRESCALER_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [PRESCALER_WIDTH-1:0]        prescaler,
  input  logic [NUM_CH*COUNTER_WIDTH-1:0]   load,
  input  logic [NUM_CH-1:0]                 enable,
  input  logic [NUM_CH-1:0]                 oneshot,
  input  logic [NUM_CH-1:0]                 irq_en,
  input  logic [NUM_CH-1:0]                 irq_clear,
  output logic [NUM_CH*COUNTER_WIDTH-1:0]   count_out,
  output logic [NUM_CH-1:0]                 pending,
  output logic                              irq
);

  logic [PRESCALER_WIDTH-1:0] psc_q, psc_d;
  logic                       tick_q, tick_d;
  logic                       irq_q, irq_d;
  logic                       any_en;

  assign any_en = |enable;

  always_ff @(posedge clk) begin
    if (rst) begin
      psc_q  <= '0;
      tick_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      psc_q  <= psc_d;
      tick_q <= tick_d;
      irq_q  <= irq_d;
    end
  end

  // Prescaler idles at 0 with no channel enabled so the first tick lands
  // prescaler+1 cycles after an enable is sampled.
  always_comb begin
    psc_d  = '0;
    tick_d = 1'b0;
    if (any_en) begin
      if (psc_q >= prescaler) begin
        psc_d  = '0;
        tick_d = 1'b1;
      end else begin
        psc_d = psc_q + 1'b1;
      end
    end
    irq_d = |(pending & irq_en);
  end

  assign irq = irq_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    timer_channel #(
      .COUNTER_WIDTH(COUNTER_WIDTH)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .tick_i   (tick_q),
      .enable_i (enable[g]),
      .oneshot_i(oneshot[g]),
      .clear_i  (irq_clear[g]),
      .load_i   (load[g*COUNTER_WIDTH +: COUNTER_WIDTH]),
      .count_o  (count_out[g*COUNTER_WIDTH +: COUNTER_WIDTH]),
      .pending_o(pending[g])
    );
  end

endmodule

// File: tb/tb_timer_bank_irq.sv
// Self-checking bench for timer_bank_irq: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the timer rules.
module tb_timer_bank_irq;

  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int PW  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [PW-1:0]     prescaler;
  logic [NCH*CW-1:0] load;
  logic [NCH-1:0]    enable, oneshot, irq_en, irq_clear;
  logic [NCH*CW-1:0] count_out;
  logic [NCH-1:0]    pending;
  logic              irq;

  timer_bank_irq #(
    .NUM_CH(NCH), .COUNTER_WIDTH(CW), .PRESCALER_WIDTH(PW)
  ) dut (
    .clk(clk), .rst(rst), .prescaler(prescaler), .load(load),
    .enable(enable), .oneshot(oneshot), .irq_en(irq_en), .irq_clear(irq_clear),
    .count_out(count_out), .pending(pending), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: channel mode 0=idle 1=running 2=finished one-shot
  int m_cnt [NCH];
  int m_mode[NCH];
  bit m_pend[NCH];
  bit m_irq;
  bit m_tick;
  int en_cycles;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit nirq;
    bit ex;
    int ld;
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_cnt[i] = 0; m_mode[i] = 0; m_pend[i] = 0;
      end
      m_irq = 0; m_tick = 0; en_cycles = 0;
    end else begin
      nirq = 0;
      for (int i = 0; i < NCH; i++) if (m_pend[i] && irq_en[i]) nirq = 1;
      for (int i = 0; i < NCH; i++) begin
        ex = 0;
        ld = int'(load[i*CW +: CW]);
        if (!enable[i]) begin
          m_mode[i] = 0; m_cnt[i] = 0;
        end else if (m_mode[i] == 0) begin
          m_mode[i] = 1; m_cnt[i] = 0;
        end else if (m_mode[i] == 1 && m_tick) begin
          if (m_cnt[i] >= ld) begin
            ex = 1; m_cnt[i] = 0;
            if (oneshot[i]) m_mode[i] = 2;
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
        end
        m_pend[i] = ex | (m_pend[i] & !irq_clear[i]);
      end
      m_irq = nirq;
      // a tick follows every (prescaler+1)-th consecutive enabled cycle
      if (|enable) begin
        en_cycles++;
        m_tick = (en_cycles % (int'(prescaler) + 1)) == 0;
      end else begin
        en_cycles = 0; m_tick = 0;
      end
    end
  endtask

  task automatic step();
    logic [NCH-1:0] mp;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int i = 0; i < NCH; i++) begin
      chk($sformatf("cnt%0d", i), 64'(count_out[i*CW +: CW]), 64'(m_cnt[i]));
      mp[i] = m_pend[i];
    end
    chk("pending", 64'(pending), 64'(mp));
    chk("irq", 64'(irq), 64'(m_irq));
  endtask

  task automatic set_load(input int ch, input int v);
    load[ch*CW +: CW] = CW'(v);
  endtask

  task automatic wait_pend(input int ch, input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!pending[ch] && n < max);
  endtask

  initial begin
    int n;
    int sets;
    int ch;
    rst = 1; prescaler = '0; load = '0; enable = '0; oneshot = '0;
    irq_en = '0; irq_clear = '0;
    step(); step();
    chk("rst_pend", 64'(pending), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_cnt", 64'(count_out), 64'd0);
    rst = 0;
    step();

    // periodic channel 0: prescaler 3, load 4 -> 20-cycle period
    prescaler = 4'd3; set_load(0, 4); irq_en[0] = 1; enable[0] = 1;
    wait_pend(0, 40, n);
    chk("first_expiry_steps", 64'(n), 64'd21);
    chk("irq_lags_pend", 64'(irq), 64'd0);
    irq_clear[0] = 1; step(); irq_clear[0] = 0;
    chk("clear_pend", 64'(pending[0]), 64'd0);
    chk("irq_rise", 64'(irq), 64'd1);
    step();
    chk("irq_fall", 64'(irq), 64'd0);
    repeat (17) step();
    irq_clear[0] = 1; step(); irq_clear[0] = 0;
    chk("set_wins", 64'(pending[0]), 64'd1);
    irq_clear[0] = 1; step(); irq_clear[0] = 0;
    wait_pend(0, 40, n);
    chk("period", 64'(n + 1), 64'd20);

    // masking leaves pending alone
    irq_en[0] = 0; step();
    chk("mask_irq", 64'(irq), 64'd0);
    chk("mask_pend", 64'(pending[0]), 64'd1);
    irq_en[0] = 1; step();
    chk("unmask_irq", 64'(irq), 64'd1);
    enable = '0; irq_clear = '1; step(); irq_clear = '0;

    // one-shot channel 1, prescaler 0, load 2
    prescaler = 4'd0; set_load(1, 2); oneshot[1] = 1; enable[1] = 1;
    wait_pend(1, 10, n);
    chk("oneshot_steps", 64'(n), 64'd4);
    irq_clear[1] = 1; step(); irq_clear[1] = 0;
    repeat (10) step();
    chk("done_no_reexpiry", 64'(pending[1]), 64'd0);
    chk("done_cnt", 64'(count_out[CW +: CW]), 64'd0);
    enable[1] = 0; step(); enable[1] = 1;
    wait_pend(1, 10, n);
    chk("retrigger_steps", 64'(n), 64'd4);
    enable = '0; irq_clear = '1; step(); irq_clear = '0;

    // load shrinks below the count
    set_load(0, 20); enable[0] = 1; n = 0;
    do begin step(); n++; end while (count_out[0 +: CW] != CW'(9) && n < 30);
    chk("reach9", 64'(count_out[0 +: CW]), 64'd9);
    set_load(0, 5); step();
    chk("shrink_expiry", 64'(pending[0]), 64'd1);
    chk("shrink_cnt", 64'(count_out[0 +: CW]), 64'd0);
    step(); step();
    rst = 1; irq_clear[0] = 1; step(); rst = 0; irq_clear[0] = 0;
    chk("midrst_cnt", 64'(count_out), 64'd0);
    chk("midrst_pend", 64'(pending), 64'd0);
    chk("midrst_irq", 64'(irq), 64'd0);

    // all channels load 0, prescaler 1: simultaneous expiries
    enable = '0; step();
    prescaler = 4'd1; load = '0; oneshot = '0; irq_clear = '1; enable = '1; sets = 0;
    repeat (20) begin
      step();
      if (pending != '0) begin
        sets++;
        chk("all_four", 64'(pending), 64'hF);
      end
    end
    chk("all_sets", 64'(sets), 64'd9);

    // full-range load on channel 2
    enable = '0; irq_clear = '1; step(); irq_clear = '0;
    prescaler = 4'd0; set_load(2, 255); enable[2] = 1; n = 0;
    do begin step(); n++; end while (count_out[2*CW +: CW] != 8'hFF && n < 300);
    chk("reach_max", 64'(count_out[2*CW +: CW]), 64'hFF);
    chk("max_no_expiry", 64'(pending[2]), 64'd0);
    step();
    chk("max_expiry", 64'(pending[2]), 64'd1);
    chk("max_wrap", 64'(count_out[2*CW +: CW]), 64'd0);

    // randomized segments, prescaler fixed within each segment
    for (int seg = 0; seg < 15; seg++) begin
      enable = '0; irq_clear = '0; rst = 0;
      step();
      prescaler = PW'($urandom_range(0, 3));
      for (int i = 0; i < NCH; i++) set_load(i, $urandom_range(0, 6));
      oneshot = NCH'($urandom); irq_en = NCH'($urandom); enable = NCH'($urandom);
      repeat (200) begin
        for (int i = 0; i < NCH; i++) begin
          if ($urandom_range(0, 15) == 0) enable[i] = ~enable[i];
          if ($urandom_range(0, 7) == 0) irq_en[i] = ~irq_en[i];
          irq_clear[i] = ($urandom_range(0, 3) == 0);
        end
        ch = $urandom_range(0, NCH - 1);
        if ($urandom_range(0, 31) == 0) set_load(ch, $urandom_range(0, 6));
        if ($urandom_range(0, 31) == 0) oneshot[ch] = ~oneshot[ch];
        rst = ($urandom_range(0, 127) == 0);
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
